// File: rtl/edsac_timing_if.sv
// Bundle of the timing generator's control inputs and timing outputs.
// Width parameters must match those given to edsac_timing_generator.
interface edsac_timing_if #(
  parameter int unsigned DIGITS = 36,
  parameter int unsigned GAP    = 0,
  parameter int unsigned MINORS = 4
);
  localparam int unsigned SLOT_W = ((DIGITS + GAP) > 1) ? $clog2(DIGITS + GAP) : 1;
  localparam int unsigned MIN_W  = (MINORS > 1) ? $clog2(MINORS) : 1;

  logic              run;
  logic              step;
  logic              clear;
  logic [DIGITS-1:0] digit_pulse;
  logic [SLOT_W-1:0] digit_index;
  logic              gap;
  logic              minor_start;
  logic              minor_end;
  logic              major_start;
  logic [MIN_W-1:0]  minor_index;
  logic              busy;

  // Controller side: drives requests, observes timing.
  modport master (
    output run, step, clear,
    input  digit_pulse, digit_index, gap, minor_start, minor_end, major_start,
    input  minor_index, busy
  );

  // Generator side.
  modport slave (
    input  run, step, clear,
    output digit_pulse, digit_index, gap, minor_start, minor_end, major_start,
    output minor_index, busy
  );
endinterface

// File: rtl/edsac_timing_generator.sv
// Digit-pulse timing generator: minor cycles of DIGITS digit slots plus GAP guard
// slots, grouped MINORS at a time into major cycles. Supports continuous run,
// single-step of one minor cycle and synchronous clear.
module edsac_timing_generator #(
  parameter int unsigned DIGITS = 36,
  parameter int unsigned GAP    = 0,
  parameter int unsigned MINORS = 4
) (
  input  logic          clk,
  input  logic          rst,
  edsac_timing_if.slave bus
);

  localparam int unsigned Slots = DIGITS + GAP;
  localparam int unsigned SlotW = (Slots > 1) ? $clog2(Slots) : 1;
  localparam int unsigned MinW  = (MINORS > 1) ? $clog2(MINORS) : 1;

  localparam logic [SlotW-1:0] LastSlot  = SlotW'(Slots - 1);
  localparam logic [SlotW-1:0] LastDigit = SlotW'(DIGITS - 1);
  localparam logic [MinW-1:0]  LastMinor = MinW'(MINORS - 1);

  typedef enum logic [1:0] {StIdle, StCont, StSingle} state_e;

  state_e           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [MinW-1:0]  minor_q, minor_d;

  logic              busy;
  logic              in_digit;
  logic [DIGITS-1:0] pulse;

  // State, slot and minor-cycle registers; every output decodes from these only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= '0;
      minor_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      minor_q <= minor_d;
    end
  end

  // Next-state logic: clear beats run beats step.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    minor_d = minor_q;
    if (bus.clear) begin
      state_d = StIdle;
      slot_d  = '0;
      minor_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          slot_d = '0;
          if (bus.run) begin
            state_d = StCont;
          end else if (bus.step) begin
            state_d = StSingle;
          end
        end
        StCont, StSingle: begin
          if (slot_q == LastSlot) begin
            // Minor cycle always completes; run decides whether another follows.
            slot_d  = '0;
            minor_d = (minor_q == LastMinor) ? '0 : minor_q + MinW'(1);
            state_d = bus.run ? StCont : StIdle;
          end else begin
            slot_d = slot_q + SlotW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Strobe decode from registered state.
  always_comb begin
    busy     = (state_q != StIdle);
    in_digit = busy && (slot_q <= LastDigit);
    pulse    = '0;
    if (in_digit) begin
      pulse = DIGITS'(1) << slot_q;
    end
  end

  assign bus.digit_pulse = pulse;
  assign bus.digit_index = busy ? slot_q : '0;
  assign bus.gap         = busy && !in_digit;
  assign bus.minor_start = busy && (slot_q == '0);
  assign bus.minor_end   = busy && (slot_q == LastSlot);
  assign bus.major_start = busy && (slot_q == '0) && (minor_q == '0);
  assign bus.minor_index = minor_q;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_edsac_timing_generator.sv
// Directed bench for edsac_timing_generator in three configurations:
// A (36,0,4), B (17,1,3), C (2,0,1). Expected vectors come from small per-config
// models of the timing outputs indexed by hand-computed slot/minor numbers.
module tb_edsac_timing_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  edsac_timing_if #(.DIGITS(36), .GAP(0), .MINORS(4)) bus_a ();
  edsac_timing_if #(.DIGITS(17), .GAP(1), .MINORS(3)) bus_b ();
  edsac_timing_if #(.DIGITS(2),  .GAP(0), .MINORS(1)) bus_c ();

  edsac_timing_generator #(.DIGITS(36), .GAP(0), .MINORS(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  edsac_timing_generator #(.DIGITS(17), .GAP(1), .MINORS(3)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );
  edsac_timing_generator #(.DIGITS(2), .GAP(0), .MINORS(1)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c.slave)
  );

  // {digit_pulse, digit_index, gap, minor_start, minor_end, major_start, minor_index, busy}
  wire [48:0] obs_a = {bus_a.digit_pulse, bus_a.digit_index, bus_a.gap, bus_a.minor_start,
                       bus_a.minor_end, bus_a.major_start, bus_a.minor_index, bus_a.busy};
  wire [28:0] obs_b = {bus_b.digit_pulse, bus_b.digit_index, bus_b.gap, bus_b.minor_start,
                       bus_b.minor_end, bus_b.major_start, bus_b.minor_index, bus_b.busy};
  wire [8:0]  obs_c = {bus_c.digit_pulse, bus_c.digit_index, bus_c.gap, bus_c.minor_start,
                       bus_c.minor_end, bus_c.major_start, bus_c.minor_index, bus_c.busy};

  function automatic logic [48:0] model_a(int slot, int minor, bit busy);
    logic [35:0] p;
    p = '0;
    if (!busy) return {36'd0, 6'd0, 4'b0000, 2'(minor), 1'b0};
    if (slot < 36) p[slot] = 1'b1;
    return {p, 6'(slot), 1'b0, slot == 0, slot == 35, (slot == 0) && (minor == 0),
            2'(minor), 1'b1};
  endfunction

  function automatic logic [28:0] model_b(int slot, int minor, bit busy);
    logic [16:0] p;
    p = '0;
    if (!busy) return {17'd0, 5'd0, 4'b0000, 2'(minor), 1'b0};
    if (slot < 17) p[slot] = 1'b1;
    return {p, 5'(slot), slot >= 17, slot == 0, slot == 17, (slot == 0) && (minor == 0),
            2'(minor), 1'b1};
  endfunction

  function automatic logic [8:0] model_c(int slot, bit busy);
    logic [1:0] p;
    p = '0;
    if (!busy) return 9'd0;
    p[slot] = 1'b1;
    return {p, 1'(slot), 1'b0, slot == 0, slot == 1, slot == 0, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL reset_a: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
    n_total++;
    if (obs_b !== model_b(0, 0, 0)) $display("FAIL reset_b: got %h want %h", obs_b, model_b(0, 0, 0));
    else n_pass++;
    n_total++;
    if (obs_c !== model_c(0, 0)) $display("FAIL reset_c: got %h want %h", obs_c, model_c(0, 0));
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL idle_after_reset: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
  endtask

  // Run held 300 clocks, then dropped mid-cycle; the minor cycle must complete.
  task automatic test_continuous();
    bus_a.run = 1'b1;
    tick();
    for (int c = 0; c < 300; c++) begin
      n_total++;
      if (obs_a !== model_a(c % 36, (c / 36) % 4, 1))
        $display("FAIL cont_c%0d: got %h want %h", c, obs_a, model_a(c % 36, (c / 36) % 4, 1));
      else n_pass++;
      tick();
    end
    bus_a.run = 1'b0;
    repeat (23) tick();
    n_total++;
    if (obs_a !== model_a(35, 0, 1)) $display("FAIL cont_last_slot: got %h want %h", obs_a, model_a(35, 0, 1));
    else n_pass++;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 1, 0)) $display("FAIL cont_stop: got %h want %h", obs_a, model_a(0, 1, 0));
    else n_pass++;
  endtask

  // One-clock run gives one minor cycle; run raised during SINGLE continues; step in CONT ignored.
  task automatic test_run_pulse();
    bus_a.run = 1'b1;
    tick();
    bus_a.run = 1'b0;
    n_total++;
    if (obs_a !== model_a(0, 1, 1)) $display("FAIL pulse_start: got %h want %h", obs_a, model_a(0, 1, 1));
    else n_pass++;
    repeat (35) tick();
    n_total++;
    if (obs_a !== model_a(35, 1, 1)) $display("FAIL pulse_end: got %h want %h", obs_a, model_a(35, 1, 1));
    else n_pass++;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 2, 0)) $display("FAIL pulse_stop: got %h want %h", obs_a, model_a(0, 2, 0));
    else n_pass++;
    bus_a.step = 1'b1;
    tick();
    bus_a.step = 1'b0;
    n_total++;
    if (obs_a !== model_a(0, 2, 1)) $display("FAIL single_start: got %h want %h", obs_a, model_a(0, 2, 1));
    else n_pass++;
    repeat (10) tick();
    bus_a.run = 1'b1;
    repeat (25) tick();
    n_total++;
    if (obs_a !== model_a(35, 2, 1)) $display("FAIL single_end: got %h want %h", obs_a, model_a(35, 2, 1));
    else n_pass++;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 3, 1)) $display("FAIL single_upgrade: got %h want %h", obs_a, model_a(0, 3, 1));
    else n_pass++;
    bus_a.run = 1'b0;
    repeat (35) tick();
    bus_a.step = 1'b1;
    tick();
    bus_a.step = 1'b0;
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL step_in_cont: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_clear();
    bus_a.run = 1'b1;
    tick();
    repeat (92) tick();
    n_total++;
    if (obs_a !== model_a(20, 2, 1)) $display("FAIL clear_pre: got %h want %h", obs_a, model_a(20, 2, 1));
    else n_pass++;
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    bus_a.run = 1'b0;
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL clear_idle: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL clear_hold: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bus_a.run = 1'b1;
    tick();
    repeat (46) tick();
    n_total++;
    if (obs_a !== model_a(10, 1, 1)) $display("FAIL areset_pre: got %h want %h", obs_a, model_a(10, 1, 1));
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL areset_immediate: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 0, 0)) $display("FAIL areset_held: got %h want %h", obs_a, model_a(0, 0, 0));
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (obs_a !== model_a(0, 0, 1)) $display("FAIL areset_restart: got %h want %h", obs_a, model_a(0, 0, 1));
    else n_pass++;
    bus_a.run = 1'b0;
    repeat (36) tick();
    n_total++;
    if (obs_a !== model_a(0, 1, 0)) $display("FAIL areset_finish: got %h want %h", obs_a, model_a(0, 1, 0));
    else n_pass++;
  endtask

  // Config B: one step gives 17 digit slots, one gap slot, then idle with minor_index advanced.
  task automatic test_single_step();
    bus_b.step = 1'b1;
    tick();
    bus_b.step = 1'b0;
    n_total++;
    if (obs_b !== model_b(0, 0, 1)) $display("FAIL step_b_s0: got %h want %h", obs_b, model_b(0, 0, 1));
    else n_pass++;
    for (int s = 1; s < 18; s++) begin
      tick();
      n_total++;
      if (obs_b !== model_b(s, 0, 1))
        $display("FAIL step_b_s%0d: got %h want %h", s, obs_b, model_b(s, 0, 1));
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs_b !== model_b(0, 1, 0)) $display("FAIL step_b_done1: got %h want %h", obs_b, model_b(0, 1, 0));
    else n_pass++;
    bus_b.step = 1'b1;
    tick();
    bus_b.step = 1'b0;
    n_total++;
    if (obs_b !== model_b(0, 1, 1)) $display("FAIL step_b_second: got %h want %h", obs_b, model_b(0, 1, 1));
    else n_pass++;
    repeat (17) tick();
    n_total++;
    if (obs_b !== model_b(17, 1, 1)) $display("FAIL step_b_gap2: got %h want %h", obs_b, model_b(17, 1, 1));
    else n_pass++;
    tick();
    n_total++;
    if (obs_b !== model_b(0, 2, 0)) $display("FAIL step_b_done2: got %h want %h", obs_b, model_b(0, 2, 0));
    else n_pass++;
  endtask

  // Config C: single minor per major, so major_start tracks minor_start every 2 clocks.
  task automatic test_minors_one();
    bus_c.run = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      n_total++;
      if (obs_c !== model_c(c % 2, 1))
        $display("FAIL minors1_c%0d: got %h want %h", c, obs_c, model_c(c % 2, 1));
      else n_pass++;
      tick();
    end
    bus_c.run = 1'b0;
    tick();
    tick();
    n_total++;
    if (obs_c !== model_c(0, 0)) $display("FAIL minors1_stop: got %h want %h", obs_c, model_c(0, 0));
    else n_pass++;
  endtask

  initial begin
    bus_a.run = 1'b0; bus_a.step = 1'b0; bus_a.clear = 1'b0;
    bus_b.run = 1'b0; bus_b.step = 1'b0; bus_b.clear = 1'b0;
    bus_c.run = 1'b0; bus_c.step = 1'b0; bus_c.clear = 1'b0;
    test_reset();
    test_continuous();
    test_run_pulse();
    test_clear();
    test_async_reset();
    test_single_step();
    test_minors_one();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
